// File: rtl/pe_array_pkg.sv
// rtl/pe_array_pkg.sv - shared widths and drain state encoding for the PE row output path
package pe_array_pkg;

   localparam int NUM_PE             = 8;
   localparam int IFMAP_WIDTH        = 8;
   localparam int WEIGHT_WIDTH       = 8;
   localparam int ACCUMULATION_WIDTH = 3;
   localparam int PSUM_WIDTH         = IFMAP_WIDTH + WEIGHT_WIDTH + ACCUMULATION_WIDTH;
   localparam int FRAC_BITS          = 7;
   localparam int OUT_WIDTH          = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } drain_state_t;

endpackage

// File: rtl/psum_requant.sv
// rtl/psum_requant.sv - round-half-up requantisation of a psum with output saturation
module psum_requant #(
   parameter int PSUM_WIDTH = 19,
   parameter int FRAC_BITS  = 7,
   parameter int OUT_WIDTH  = 8
) (
   input  logic signed [PSUM_WIDTH-1:0] psum_i,
   output logic signed [OUT_WIDTH-1:0]  data_o
);

   // One guard bit so the rounding add can never wrap.
   localparam int EW = PSUM_WIDTH + 1;
   localparam logic signed [EW-1:0] HALF  = EW'(2 ** (FRAC_BITS - 1));
   localparam logic signed [EW-1:0] MAX_V = EW'(2 ** (OUT_WIDTH - 1) - 1);
   localparam logic signed [EW-1:0] MIN_V = EW'(-(2 ** (OUT_WIDTH - 1)));

   logic signed [EW-1:0] sum;
   logic signed [EW-1:0] rnd;

   // Add half an LSB, drop the fraction (floor), then clamp to the output range.
   always_comb begin
      sum = {psum_i[PSUM_WIDTH-1], psum_i} + HALF;
      rnd = sum >>> FRAC_BITS;
      if (rnd > MAX_V) begin
         data_o = MAX_V[OUT_WIDTH-1:0];
      end else if (rnd < MIN_V) begin
         data_o = MIN_V[OUT_WIDTH-1:0];
      end else begin
         data_o = rnd[OUT_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/psum_drain.sv
// rtl/psum_drain.sv - captures a PE row of psums and streams them out requantised
module psum_drain
   import pe_array_pkg::*;
(
   input  logic                           clk,
   input  logic                           nrst,
   input  logic                           en,
   input  logic                           load_i,
   input  logic [NUM_PE*PSUM_WIDTH-1:0]   psum_i,
   output logic                           out_valid_o,
   input  logic                           out_ready_i,
   output logic signed [OUT_WIDTH-1:0]    out_data_o,
   output logic [$clog2(NUM_PE)-1:0]      out_idx_o,
   output logic                           out_last_o,
   output logic                           busy_o,
   output logic                           done_o
);

   localparam int IDX_W = $clog2(NUM_PE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

   drain_state_t            state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    done_q, done_d;
   logic                    buf_load;
   logic [PSUM_WIDTH-1:0]   buf_q [NUM_PE];

   // Next-state: capture only from IDLE, advance index on each accepted beat.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      done_d   = 1'b0;
      buf_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_i) begin
               state_d  = DRAIN;
               idx_d    = '0;
               buf_load = 1'b1;
            end
         end
         DRAIN: begin
            if (out_ready_i) begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, index, done pulse and psum buffer; reset and disable both clear everything.
   always_ff @(posedge clk) begin
      if (!nrst || !en) begin
         state_q <= IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
         for (int k = 0; k < NUM_PE; k++) begin
            buf_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         if (buf_load) begin
            for (int k = 0; k < NUM_PE; k++) begin
               buf_q[k] <= psum_i[k*PSUM_WIDTH +: PSUM_WIDTH];
            end
         end
      end
   end

   psum_requant #(
      .PSUM_WIDTH (PSUM_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .OUT_WIDTH  (OUT_WIDTH)
   ) u_requant (
      .psum_i (buf_q[idx_q]),
      .data_o (out_data_o)
   );

   assign out_valid_o = (state_q == DRAIN);
   assign busy_o      = (state_q == DRAIN);
   assign out_idx_o   = idx_q;
   assign out_last_o  = (state_q == DRAIN) && (idx_q == LAST_IDX);
   assign done_o      = done_q;

endmodule

// File: tb/tb_psum_drain.sv
// tb/tb_psum_drain.sv - self-checking bench for psum_drain
module tb_psum_drain;

   localparam int NUM = 8;
   localparam int PW  = 19;

   typedef int vals_t [NUM];
   typedef struct {
      vals_t psum;
      vals_t exp;
      int    mode;
      bit    noise;
   } vec_t;

   logic                 clk = 1'b0;
   logic                 nrst, en, load_i, out_ready_i;
   logic [NUM*PW-1:0]    psum_i;
   logic                 out_valid_o, out_last_o, busy_o, done_o;
   logic signed [7:0]    out_data_o;
   logic [2:0]           out_idx_o;

   int pass_cnt  = 0;
   int total_cnt = 0;

   psum_drain dut (
      .clk         (clk),
      .nrst        (nrst),
      .en          (en),
      .load_i      (load_i),
      .psum_i      (psum_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_idx_o   (out_idx_o),
      .out_last_o  (out_last_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Reference: round half toward +inf on a 2^7 grid, then clamp to int8.
   function automatic int ref_requant(input int x);
      int a, q;
      a = x + 64;
      q = (a >= 0) ? a / 128 : -((-a + 127) / 128);
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      return q;
   endfunction

   function automatic vals_t rand_vals();
      vals_t v;
      for (int k = 0; k < NUM; k++) begin
         case ($urandom_range(0, 3))
            0: v[k] = int'($urandom_range(0, 40000)) - 20000;
            1: v[k] = int'($urandom_range(0, 524287)) - 262144;
            2: v[k] = int'($urandom_range(0, 1000)) - 500;
            default: v[k] = (int'($urandom_range(0, 400)) - 200) * 64;
         endcase
      end
      return v;
   endfunction

   function automatic vals_t model(input vals_t v);
      vals_t e;
      for (int k = 0; k < NUM; k++) e[k] = ref_requant(v[k]);
      return e;
   endfunction

   task automatic drive_load(input vals_t v);
      for (int k = 0; k < NUM; k++) psum_i[k*PW +: PW] = PW'(v[k]);
      load_i      = 1'b1;
      out_ready_i = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, int'(out_valid_o), 0);
      chk({tag, "_data"},  int'(out_data_o), 0);
      chk({tag, "_idx"},   int'(out_idx_o), 0);
      chk({tag, "_last"},  int'(out_last_o), 0);
      chk({tag, "_busy"},  int'(busy_o), 0);
      chk({tag, "_done"},  int'(done_o), 0);
   endtask

   // Called in the negedge slot where the load was driven; ends in the done_o negedge.
   task automatic run_drain(input vals_t exp, input int mode, input bit noise, input string tag);
      int n = 0;
      int cyc = 0;
      bit rdy;
      while (n < NUM && cyc < 300) begin
         @(negedge clk);
         cyc++;
         load_i = noise;
         if (noise) for (int k = 0; k < NUM; k++) psum_i[k*PW +: PW] = PW'($urandom);
         chk({tag, "_valid"}, int'(out_valid_o), 1);
         chk({tag, "_busy"},  int'(busy_o), 1);
         chk({tag, "_done_mid"}, int'(done_o), 0);
         chk({tag, "_data"}, int'(out_data_o), exp[n]);
         chk({tag, "_idx"},  int'(out_idx_o), n);
         chk({tag, "_last"}, int'(out_last_o), (n == NUM - 1) ? 1 : 0);
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 3 == 1);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         out_ready_i = rdy;
         if (rdy && out_valid_o) n++;
      end
      chk({tag, "_beats"}, n, NUM);
      @(negedge clk);
      load_i      = 1'b0;
      out_ready_i = 1'b0;
      chk({tag, "_done"},       int'(done_o), 1);
      chk({tag, "_valid_end"},  int'(out_valid_o), 0);
      chk({tag, "_busy_end"},   int'(busy_o), 0);
      chk({tag, "_last_end"},   int'(out_last_o), 0);
   endtask

   task automatic abort_at(input vals_t v, input int stop, input bit use_en, input string tag);
      vals_t e;
      e = model(v);
      @(negedge clk);
      drive_load(v);
      for (int i = 0; i <= stop; i++) begin
         @(negedge clk);
         load_i      = 1'b0;
         out_ready_i = 1'b1;
         chk({tag, "_idx"},  int'(out_idx_o), i);
         chk({tag, "_data"}, int'(out_data_o), e[i]);
      end
      if (use_en) en = 1'b0; else nrst = 1'b0;
      @(negedge clk);
      chk_idle({tag, "_clr"});
      en = 1'b1; nrst = 1'b1; out_ready_i = 1'b0;
      @(negedge clk);
      chk_idle({tag, "_after"});
   endtask

   vec_t  tbl [3];
   vals_t va, vb, vc;

   initial begin
      tbl[0].psum = '{640, 191, 192, -192, 0, 63, 64, -65};
      tbl[0].exp  = '{5, 1, 2, -1, 0, 0, 1, -1};
      tbl[0].mode = 0; tbl[0].noise = 1'b0;
      tbl[1].psum = '{16256, 20000, 262143, -20000, -262144, 0, -64, -193};
      tbl[1].exp  = '{127, 127, 127, -128, -128, 0, 0, -2};
      tbl[1].mode = 1; tbl[1].noise = 1'b0;
      tbl[2].psum = '{-65, 64, 63, 0, -192, 192, 191, 640};
      tbl[2].exp  = '{-1, 1, 0, 0, -1, 2, 1, 5};
      tbl[2].mode = 2; tbl[2].noise = 1'b1;

      nrst = 1'b0; en = 1'b1; load_i = 1'b0; out_ready_i = 1'b0; psum_i = '0;
      repeat (3) @(negedge clk);
      chk_idle("reset");
      nrst = 1'b1;
      @(negedge clk);
      chk_idle("idle");

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive_load(tbl[i].psum);
         run_drain(tbl[i].exp, tbl[i].mode, tbl[i].noise, $sformatf("tbl%0d", i));
      end

      // Loads in the done_o cycle: back-to-back drains with a single gap cycle.
      va = rand_vals(); vb = rand_vals(); vc = rand_vals();
      @(negedge clk);
      drive_load(va);
      run_drain(model(va), 0, 1'b0, "b2b_a");
      drive_load(vb);
      run_drain(model(vb), 0, 1'b0, "b2b_b");
      drive_load(vc);
      run_drain(model(vc), 2, 1'b1, "b2b_c");
      @(negedge clk);
      chk("b2b_idle_done", int'(done_o), 0);

      abort_at('{1000, -1000, 300, 5000, 700, 900, -900, 100}, 3, 1'b0, "nrst_abort");
      abort_at('{-3000, 2000, 128, -128, 4000, 9999, 1, 2}, 5, 1'b1, "en_abort");

      // en low blocks a load.
      @(negedge clk);
      en = 1'b0;
      drive_load(va);
      @(negedge clk);
      load_i = 1'b0; en = 1'b1;
      chk_idle("en_blocks_load");

      for (int r = 0; r < 6; r++) begin
         va = rand_vals();
         @(negedge clk);
         drive_load(va);
         run_drain(model(va), 2, r[0], $sformatf("rand%0d", r));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
